// File: rtl/multi_timer.sv
// Multi-channel MM:SS timer with a shared one-second prescaler.
// One multi_timer_ch per channel; the top muxes the selected channel onto the BCD outputs.

module multi_timer_ch #(
    parameter int ALARM_SEC = 10,
    parameter int MAX_MIN   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       sel,
    input  logic       m_inc,
    input  logic       s_inc,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       up_down,
    output logic [3:0] m_hi,
    output logic [3:0] m_lo,
    output logic [3:0] s_hi,
    output logic [3:0] s_lo,
    output logic       mode_up,
    output logic       run,
    output logic       arm
);
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, ALARM} state_e;

    localparam int AW = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC);
    localparam logic [3:0] MAX_HI = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_LO = 4'(MAX_MIN % 10);

    state_e        state_q, state_d;
    logic [3:0]    mh_q, mh_d, ml_q, ml_d, sh_q, sh_d, sl_q, sl_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic [3:0]    inc_mh, inc_ml;
    logic          editable;

    assign editable = (state_q == IDLE) || (state_q == PAUSED);

    // Minute increment shared by M_INC and the count-up carry; wraps past MAX_MIN.
    always_comb begin
        if (mh_q == MAX_HI && ml_q == MAX_LO) begin
            inc_mh = 4'd0;
            inc_ml = 4'd0;
        end else if (ml_q == 4'd9) begin
            inc_mh = mh_q + 4'd1;
            inc_ml = 4'd0;
        end else begin
            inc_mh = mh_q;
            inc_ml = ml_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        mh_d    = mh_q;
        ml_d    = ml_q;
        sh_d    = sh_q;
        sl_d    = sl_q;
        mode_d  = mode_q;
        acnt_d  = acnt_q;
        if (sel && clear) begin
            state_d = IDLE;
            mh_d    = 4'd0;
            ml_d    = 4'd0;
            sh_d    = 4'd0;
            sl_d    = 4'd0;
            mode_d  = 1'b0;
            acnt_d  = '0;
        end else if (sel && stop) begin
            state_d = (state_q == RUNNING) ? PAUSED : IDLE;
            acnt_d  = '0;
        end else begin
            if (sel && start) begin
                if (editable && (mode_q || {mh_q, ml_q, sh_q, sl_q} != 16'h0))
                    state_d = RUNNING;
            end else if (sel && up_down) begin
                if (state_q == IDLE) mode_d = ~mode_q;
            end else if (sel && m_inc) begin
                if (editable) begin
                    mh_d = inc_mh;
                    ml_d = inc_ml;
                end
            end else if (sel && s_inc) begin
                if (editable) begin
                    if (sl_q != 4'd9) begin
                        sl_d = sl_q + 4'd1;
                    end else begin
                        sl_d = 4'd0;
                        sh_d = (sh_q == 4'd5) ? 4'd0 : sh_q + 4'd1;
                    end
                end
            end
            // Commands that can coexist with a tick only touch IDLE/PAUSED, so the tick sees state_q.
            if (tick && state_q == RUNNING) begin
                if (mode_q) begin
                    if (sl_q != 4'd9) begin
                        sl_d = sl_q + 4'd1;
                    end else begin
                        sl_d = 4'd0;
                        if (sh_q != 4'd5) begin
                            sh_d = sh_q + 4'd1;
                        end else begin
                            sh_d = 4'd0;
                            mh_d = inc_mh;
                            ml_d = inc_ml;
                        end
                    end
                    if ({mh_d, ml_d, sh_d, sl_d} == {MAX_HI, MAX_LO, 4'd5, 4'd9}) begin
                        state_d = ALARM;
                        acnt_d  = '0;
                    end
                end else begin
                    if (sl_q != 4'd0) begin
                        sl_d = sl_q - 4'd1;
                    end else begin
                        sl_d = 4'd9;
                        if (sh_q != 4'd0) begin
                            sh_d = sh_q - 4'd1;
                        end else begin
                            sh_d = 4'd5;
                            if (ml_q != 4'd0) begin
                                ml_d = ml_q - 4'd1;
                            end else begin
                                ml_d = 4'd9;
                                mh_d = mh_q - 4'd1;
                            end
                        end
                    end
                    if ({mh_d, ml_d, sh_d, sl_d} == 16'h0) begin
                        state_d = ALARM;
                        acnt_d  = '0;
                    end
                end
            end else if (tick && state_q == ALARM) begin
                if (int'(acnt_q) + 1 >= ALARM_SEC) begin
                    state_d = IDLE;
                    acnt_d  = '0;
                end else begin
                    acnt_d = acnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mh_q    <= 4'd0;
            ml_q    <= 4'd0;
            sh_q    <= 4'd0;
            sl_q    <= 4'd0;
            mode_q  <= 1'b0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mh_q    <= mh_d;
            ml_q    <= ml_d;
            sh_q    <= sh_d;
            sl_q    <= sl_d;
            mode_q  <= mode_d;
            acnt_q  <= acnt_d;
        end
    end

    assign m_hi    = mh_q;
    assign m_lo    = ml_q;
    assign s_hi    = sh_q;
    assign s_lo    = sl_q;
    assign mode_up = mode_q;
    assign run     = (state_q == RUNNING);
    assign arm     = (state_q == ALARM);
endmodule

module multi_timer #(
    parameter int CHANNELS  = 2,
    parameter int TICK_DIV  = 244140,
    parameter int ALARM_SEC = 10,
    parameter int MAX_MIN   = 99
) (
    input  logic                CLK,
    input  logic                RES,
    input  logic [1:0]          CH_SEL,
    input  logic                M_INC,
    input  logic                S_INC,
    input  logic                START,
    input  logic                STOP,
    input  logic                CLEAR,
    input  logic                UP_DOWN,
    output logic [3:0]          M_HI,
    output logic [3:0]          M_LO,
    output logic [3:0]          S_HI,
    output logic [3:0]          S_LO,
    output logic [CHANNELS-1:0] RUN,
    output logic [CHANNELS-1:0] ARM,
    output logic                ARM_ANY,
    output logic                MODE_UP,
    output logic                TICK
);
    localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

    logic [PW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    logic [CHANNELS-1:0][3:0] ch_mh, ch_ml, ch_sh, ch_sl;
    logic [CHANNELS-1:0]      ch_mode;

    // Free-running prescaler: START never resyncs it, so the first tick after START is up to one second away.
    always_comb begin
        tick_d = (div_q == PW'(TICK_DIV - 1));
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        multi_timer_ch #(
            .ALARM_SEC (ALARM_SEC),
            .MAX_MIN   (MAX_MIN)
        ) u_ch (
            .clk     (CLK),
            .rst     (RES),
            .tick    (tick_q),
            .sel     (CH_SEL == 2'(i)),
            .m_inc   (M_INC),
            .s_inc   (S_INC),
            .start   (START),
            .stop    (STOP),
            .clear   (CLEAR),
            .up_down (UP_DOWN),
            .m_hi    (ch_mh[i]),
            .m_lo    (ch_ml[i]),
            .s_hi    (ch_sh[i]),
            .s_lo    (ch_sl[i]),
            .mode_up (ch_mode[i]),
            .run     (RUN[i]),
            .arm     (ARM[i])
        );
    end

    always_comb begin
        M_HI    = 4'd0;
        M_LO    = 4'd0;
        S_HI    = 4'd0;
        S_LO    = 4'd0;
        MODE_UP = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (CH_SEL == 2'(c)) begin
                M_HI    = ch_mh[c];
                M_LO    = ch_ml[c];
                S_HI    = ch_sh[c];
                S_LO    = ch_sl[c];
                MODE_UP = ch_mode[c];
            end
        end
    end

    assign ARM_ANY = |ARM;
    assign TICK    = tick_q;
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: expectations queued when stimulus is driven, popped when sampled.

module tb_multi_timer;
    logic       CLK = 1'b0;
    logic       RES;
    logic [1:0] CH_SEL;
    logic       M_INC, S_INC, START, STOP, CLEAR, UP_DOWN;

    logic [3:0] a_mh, a_ml, a_sh, a_sl, b_mh, b_ml, b_sh, b_sl;
    logic [1:0] a_run, a_arm, b_run, b_arm;
    logic       a_any, a_mode, a_tick, b_any, b_mode, b_tick;

    localparam logic [5:0] C_CLR = 6'b100000, C_STOP = 6'b010000, C_START = 6'b001000;
    localparam logic [5:0] C_UD  = 6'b000100, C_MI   = 6'b000010, C_SI    = 6'b000001;

    always #5 CLK = ~CLK;

    multi_timer #(.CHANNELS(2), .TICK_DIV(4), .ALARM_SEC(3), .MAX_MIN(99)) dut_a (
        .CLK(CLK), .RES(RES), .CH_SEL(CH_SEL), .M_INC(M_INC), .S_INC(S_INC), .START(START),
        .STOP(STOP), .CLEAR(CLEAR), .UP_DOWN(UP_DOWN), .M_HI(a_mh), .M_LO(a_ml), .S_HI(a_sh),
        .S_LO(a_sl), .RUN(a_run), .ARM(a_arm), .ARM_ANY(a_any), .MODE_UP(a_mode), .TICK(a_tick));

    multi_timer #(.CHANNELS(2), .TICK_DIV(4), .ALARM_SEC(3), .MAX_MIN(1)) dut_b (
        .CLK(CLK), .RES(RES), .CH_SEL(CH_SEL), .M_INC(M_INC), .S_INC(S_INC), .START(START),
        .STOP(STOP), .CLEAR(CLEAR), .UP_DOWN(UP_DOWN), .M_HI(b_mh), .M_LO(b_ml), .S_HI(b_sh),
        .S_LO(b_sl), .RUN(b_run), .ARM(b_arm), .ARM_ANY(b_any), .MODE_UP(b_mode), .TICK(b_tick));

    typedef struct { string tag; logic [15:0] exp; } exp_t;
    exp_t sb[$];
    int   total  = 0;
    int   passes = 0;

    function automatic logic [15:0] ta(); return {a_mh, a_ml, a_sh, a_sl}; endfunction
    function automatic logic [15:0] tb_(); return {b_mh, b_ml, b_sh, b_sl}; endfunction
    function automatic logic [15:0] z2(input logic [1:0] v); return {14'b0, v}; endfunction
    function automatic logic [15:0] z1(input logic v); return {15'b0, v}; endfunction

    task automatic push(input string tag, input logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        exp_t x;
        total++;
        assert (sb.size() != 0) else begin
            $error("FAIL scoreboard_empty: observed %h expected a queued value", obs);
            return;
        end
        x = sb.pop_front();
        assert (obs === x.exp) passes++;
        else $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
    endtask

    task automatic cmd(input logic [5:0] c);
        {CLEAR, STOP, START, UP_DOWN, M_INC, S_INC} = c;
        @(negedge CLK);
        {CLEAR, STOP, START, UP_DOWN, M_INC, S_INC} = 6'b0;
    endtask

    task automatic cmd_n(input logic [5:0] c, input int n);
        repeat (n) cmd(c);
    endtask

    // Returns at the negedge just after the edge that consumed a TICK.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (a_tick) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        total++;
        assert (found) passes++;
        else $error("FAIL tick_timeout: observed no TICK expected TICK within 20 cycles");
        @(negedge CLK);
    endtask

    initial begin
        RES = 1'b1;
        CH_SEL = 2'd0;
        {CLEAR, STOP, START, UP_DOWN, M_INC, S_INC} = 6'b0;

        // Reset state
        push("rst_time", 16'h0000); push("rst_run", 16'h0); push("rst_arm", 16'h0);
        push("rst_tick", 16'h0);
        repeat (2) @(negedge CLK);
        pop_chk(ta()); pop_chk(z2(a_run)); pop_chk(z2(a_arm)); pop_chk(z1(a_tick));
        RES = 1'b0;
        @(negedge CLK);

        // ch0 countdown from 00:02 into ALARM and back to IDLE
        cmd_n(C_SI, 2);
        cmd(C_START);
        push("a_start_time", 16'h0002); push("a_start_run", 16'h0001);
        pop_chk(ta()); pop_chk(z2(a_run));
        push("a_tick1", 16'h0001);
        wait_tick();
        pop_chk(ta());
        push("a_tick2_time", 16'h0000); push("a_tick2_arm", 16'h0001);
        push("a_tick2_any", 16'h0001); push("a_tick2_run", 16'h0000);
        wait_tick();
        pop_chk(ta()); pop_chk(z2(a_arm)); pop_chk(z1(a_any)); pop_chk(z2(a_run));
        push("a_alarm_hold", 16'h0001);
        repeat (2) wait_tick();
        pop_chk(z2(a_arm));
        push("a_alarm_end_arm", 16'h0000); push("a_alarm_end_time", 16'h0000);
        wait_tick();
        pop_chk(z2(a_arm)); pop_chk(ta());

        // ch1 borrow from 01:00, ch0 untouched
        CH_SEL = 2'd1;
        cmd(C_MI);
        cmd(C_START);
        push("c1_borrow", 16'h0059); push("c1_run", 16'h0002);
        wait_tick();
        pop_chk(ta()); pop_chk(z2(a_run));
        CH_SEL = 2'd0;
        push("c0_idle_time", 16'h0000);
        #1 pop_chk(ta());
        CH_SEL = 2'd1;
        cmd(C_STOP);
        cmd(C_UD);
        push("c1_pause_mode", 16'h0000); push("c1_pause_run", 16'h0000);
        pop_chk(z1(a_mode)); pop_chk(z2(a_run));
        push("c1_pause_hold", 16'h0059);
        wait_tick();
        pop_chk(ta());
        cmd(C_STOP);
        cmd(C_UD);
        push("c1_idle_mode", 16'h0001); push("c1_idle_time", 16'h0059);
        pop_chk(z1(a_mode)); pop_chk(ta());
        cmd(C_CLR);
        push("c1_clr_time", 16'h0000); push("c1_clr_mode", 16'h0000);
        pop_chk(ta()); pop_chk(z1(a_mode));

        // Set wraps and out-of-range select
        CH_SEL = 2'd0;
        cmd_n(C_SI, 61);
        push("s_wrap", 16'h0001);
        pop_chk(ta());
        cmd_n(C_MI, 99);
        push("m_max", 16'h9901);
        pop_chk(ta());
        CH_SEL = 2'd3;
        push("oor_read", 16'h0000);
        #1 pop_chk(ta());
        cmd(C_MI);
        CH_SEL = 2'd0;
        push("oor_ignored", 16'h9901);
        #1 pop_chk(ta());
        cmd(C_MI);
        push("m_wrap", 16'h0001);
        pop_chk(ta());

        // Simultaneous commands and blocked START
        cmd(C_CLR);
        cmd_n(C_SI, 5);
        cmd(C_START | C_STOP);
        push("stop_wins_run", 16'h0000); push("stop_wins_time", 16'h0005);
        pop_chk(z2(a_run)); pop_chk(ta());
        push("stop_wins_tick", 16'h0005);
        wait_tick();
        pop_chk(ta());
        cmd(C_CLR | C_MI);
        push("clr_wins", 16'h0000);
        pop_chk(ta());
        cmd(C_START);
        push("start_zero_down", 16'h0000);
        pop_chk(z2(a_run));

        // Count-up to MAX_MIN:59 on the MAX_MIN=1 instance
        cmd(C_UD);
        cmd(C_START);
        push("up_mode", 16'h0001); push("up_run", 16'h0001);
        pop_chk(z1(b_mode)); pop_chk(z2(b_run));
        push("up_0059", 16'h0059);
        repeat (59) wait_tick();
        pop_chk(tb_());
        push("up_carry", 16'h0100);
        wait_tick();
        pop_chk(tb_());
        push("up_0158", 16'h0158); push("up_0158_arm", 16'h0000);
        repeat (58) wait_tick();
        pop_chk(tb_()); pop_chk(z2(b_arm));
        push("up_max", 16'h0159); push("up_max_arm", 16'h0001);
        push("up_max_any", 16'h0001); push("up_max_run", 16'h0000);
        wait_tick();
        pop_chk(tb_()); pop_chk(z2(b_arm)); pop_chk(z1(b_any)); pop_chk(z2(b_run));

        // Reset during ch0 ALARM with ch1 RUNNING
        CH_SEL = 2'd1;
        cmd(C_MI);
        cmd(C_START);
        push("pre_rst_run", 16'h0002); push("pre_rst_arm", 16'h0001);
        pop_chk(z2(b_run)); pop_chk(z2(b_arm));
        RES = 1'b1;
        push("rst_b_time", 16'h0000); push("rst_b_run", 16'h0000); push("rst_b_arm", 16'h0000);
        push("rst_b_any", 16'h0000); push("rst_b_tick", 16'h0000); push("rst_a_any", 16'h0000);
        #1;
        pop_chk(tb_()); pop_chk(z2(b_run)); pop_chk(z2(b_arm));
        pop_chk(z1(b_any)); pop_chk(z1(b_tick)); pop_chk(z1(a_any));
        @(negedge CLK);
        RES = 1'b0;
        push("post_rst_arm", 16'h0000); push("post_rst_run", 16'h0000);
        push("post_rst_c1", 16'h0000);
        repeat (4) wait_tick();
        pop_chk(z2(b_arm)); pop_chk(z2(b_run)); pop_chk(tb_());
        CH_SEL = 2'd0;
        push("post_rst_c0", 16'h0000); push("post_rst_mode", 16'h0000);
        #1 pop_chk(tb_()); pop_chk(z1(b_mode));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
